button_press_classifier: RTL and testbench

BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

---
 rtl/button_press_classifier.sv | 140 ++++++++++++++
 tb/tb_button_press_classifier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : button_press_classifier
// Description : Classifies a debounced button level into short-press,
//               long-press and optional auto-repeat strobes.
//               Optional feature macro: AUTOREPEAT_EN (auto-repeat strobes).
// Revision    : 1.0 - initial release
// ============================================================================
module button_press_classifier #(
    parameter int COUNT_MIN    = 4,
    parameter int COUNT_LONG   = 250000000,
    parameter int COUNT_REPEAT = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic pulse_short,
    output logic pulse_long,
    output logic pulse_repeat,
    output logic held
);

    localparam int c_press_w = $clog2(COUNT_LONG + 1);

    localparam logic [1:0] c_st_wait_release = 2'd0;
    localparam logic [1:0] c_st_idle         = 2'd1;
    localparam logic [1:0] c_st_pressed      = 2'd2;
    localparam logic [1:0] c_st_long_held    = 2'd3;

    localparam logic [c_press_w-1:0] c_press_one  = c_press_w'(1);
    localparam logic [c_press_w-1:0] c_count_min  = c_press_w'(COUNT_MIN);
    localparam logic [c_press_w-1:0] c_count_long = c_press_w'(COUNT_LONG);

    if ((COUNT_MIN < 1) || (COUNT_MIN >= COUNT_LONG) || (COUNT_REPEAT < 2)) begin : g_bad_params
        $error("button_press_classifier: unsupported parameter values");
    end

    logic [1:0]           r_state;
    logic [c_press_w-1:0] r_press_cnt;
    logic                 r_pulse_short;
    logic                 r_pulse_long;
    logic                 r_held;

    logic [1:0]           w_state_nxt;
    logic [c_press_w-1:0] w_press_nxt;
    logic [c_press_w-1:0] w_press_inc;
    logic                 w_short;
    logic                 w_long;

    assign w_press_inc = r_press_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_press_nxt = r_press_cnt;
        w_short     = 1'b0;
        w_long      = 1'b0;
        case (r_state)
            c_st_wait_release: begin
                if (!boton_in) w_state_nxt = c_st_idle;
            end
            c_st_idle: begin
                if (boton_in) begin
                    w_state_nxt = c_st_pressed;
                    w_press_nxt = c_press_one;
                end
            end
            c_st_pressed: begin
                if (boton_in) begin
                    w_press_nxt = w_press_inc;
                    // Leaving PRESSED at the threshold keeps press_cnt from ever wrapping.
                    if (w_press_inc == c_count_long) begin
                        w_long      = 1'b1;
                        w_state_nxt = c_st_long_held;
                    end
                end else begin
                    w_state_nxt = c_st_idle;
                    w_short     = (r_press_cnt >= c_count_min);
                end
            end
            c_st_long_held: begin
                if (!boton_in) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_wait_release;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_wait_release;
            r_press_cnt   <= '0;
            r_pulse_short <= 1'b0;
            r_pulse_long  <= 1'b0;
            r_held        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_press_cnt   <= w_press_nxt;
            r_pulse_short <= w_short;
            r_pulse_long  <= w_long;
            r_held        <= (w_state_nxt == c_st_pressed) || (w_state_nxt == c_st_long_held);
        end
    end

    assign pulse_short = r_pulse_short;
    assign pulse_long  = r_pulse_long;
    assign held        = r_held;

`ifdef AUTOREPEAT_EN
    localparam int c_rep_w = $clog2(COUNT_REPEAT);
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(COUNT_REPEAT - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_pulse_repeat;

    // The repeat strobe fires on the sample that finds the counter at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_cnt      <= '0;
            r_pulse_repeat <= 1'b0;
        end else begin
            r_pulse_repeat <= 1'b0;
            if (w_long) begin
                r_rep_cnt <= '0;
            end else if ((r_state == c_st_long_held) && boton_in) begin
                if (r_rep_cnt == c_rep_last) begin
                    r_pulse_repeat <= 1'b1;
                    r_rep_cnt      <= '0;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end
        end
    end

    assign pulse_repeat = r_pulse_repeat;
`else
    assign pulse_repeat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_press_classifier
// Description : Directed self-checking bench for button_press_classifier
//               (COUNT_MIN=4, COUNT_LONG=20, COUNT_REPEAT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_press_classifier;

    logic clk;
    logic reset;
    logic boton_in;
    logic pulse_short;
    logic pulse_long;
    logic pulse_repeat;
    logic held;

    int checks;
    int errors;

    int hi;
    int n_short;
    int n_long;
    int n_rep;
    int n_held;
    int n_multi;
    int long_at;
    int rep_at [0:7];

    button_press_classifier #(
        .COUNT_MIN   (4),
        .COUNT_LONG  (20),
        .COUNT_REPEAT(8)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .boton_in    (boton_in),
        .pulse_short (pulse_short),
        .pulse_long  (pulse_long),
        .pulse_repeat(pulse_repeat),
        .held        (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_counts();
        n_short = 0;
        n_long  = 0;
        n_rep   = 0;
        n_held  = 0;
        n_multi = 0;
        long_at = -1;
        for (int i = 0; i < 8; i++) rep_at[i] = -1;
    endtask

    // One sample of boton_in; outputs observed 1 time unit after the edge.
    task automatic cyc(input logic b);
        boton_in = b;
        hi = b ? hi + 1 : 0;
        @(posedge clk);
        #1;
        if (pulse_short) n_short++;
        if (pulse_long) begin
            n_long++;
            long_at = hi;
        end
        if (pulse_repeat) begin
            if (n_rep < 8) rep_at[n_rep] = hi;
            n_rep++;
        end
        if (held) n_held++;
        if ((int'(pulse_short) + int'(pulse_long) + int'(pulse_repeat)) > 1) n_multi++;
    endtask

    task automatic cycles(input logic b, input int n);
        for (int i = 0; i < n; i++) cyc(b);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(1'b1, 3);
        checks++;
        if (held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", held); end
        checks++;
        if (pulse_short !== 1'b0) begin errors++; $display("FAIL reset_short got %b want 0", pulse_short); end
        checks++;
        if (pulse_long !== 1'b0) begin errors++; $display("FAIL reset_long got %b want 0", pulse_long); end
        checks++;
        if (pulse_repeat !== 1'b0) begin errors++; $display("FAIL reset_repeat got %b want 0", pulse_repeat); end
        reset = 1'b0;
    endtask

    task automatic test_short_press();
        clear_counts();
        cycles(1'b0, 3);
        cycles(1'b1, 10);
        cyc(1'b0);
        checks++;
        if (pulse_short !== 1'b1) begin errors++; $display("FAIL short_at_release got %b want 1", pulse_short); end
        cyc(1'b0);
        checks++;
        if (n_short != 1) begin errors++; $display("FAIL short_count got %0d want 1", n_short); end
        checks++;
        if (n_long != 0) begin errors++; $display("FAIL short_no_long got %0d want 0", n_long); end
        checks++;
        if (n_held != 10) begin errors++; $display("FAIL short_held_cycles got %0d want 10", n_held); end
    endtask

    task automatic test_glitch();
        clear_counts();
        cycles(1'b1, 3);
        cycles(1'b0, 2);
        checks++;
        if ((n_short + n_long + n_rep) != 0) begin
            errors++; $display("FAIL glitch_strobes got %0d want 0", n_short + n_long + n_rep);
        end
        checks++;
        if (held !== 1'b0) begin errors++; $display("FAIL glitch_held got %b want 0", held); end
        // A press of exactly COUNT_MIN samples right after shows the block is back in IDLE.
        cycles(1'b1, 4);
        cycles(1'b0, 2);
        checks++;
        if (n_short != 1) begin errors++; $display("FAIL min_press_short got %0d want 1", n_short); end
    endtask

    task automatic test_boundary();
        clear_counts();
        cycles(1'b1, 19);
        cycles(1'b0, 2);
        checks++;
        if (n_short != 1) begin errors++; $display("FAIL b19_short got %0d want 1", n_short); end
        checks++;
        if (n_long != 0) begin errors++; $display("FAIL b19_long got %0d want 0", n_long); end
        clear_counts();
        cycles(1'b1, 20);
        cycles(1'b0, 2);
        checks++;
        if (n_long != 1) begin errors++; $display("FAIL b20_long got %0d want 1", n_long); end
        checks++;
        if (long_at != 20) begin errors++; $display("FAIL b20_long_sample got %0d want 20", long_at); end
        checks++;
        if (n_short != 0) begin errors++; $display("FAIL b20_short got %0d want 0", n_short); end
    endtask

    task automatic test_auto_repeat();
        clear_counts();
        cycles(1'b1, 40);
        cycles(1'b0, 2);
        checks++;
        if (n_long != 1) begin errors++; $display("FAIL rep_long got %0d want 1", n_long); end
        checks++;
        if (long_at != 20) begin errors++; $display("FAIL rep_long_sample got %0d want 20", long_at); end
        checks++;
        if (n_held != 40) begin errors++; $display("FAIL rep_held_cycles got %0d want 40", n_held); end
        checks++;
        if (n_multi != 0) begin errors++; $display("FAIL rep_one_hot got %0d want 0", n_multi); end
`ifdef AUTOREPEAT_EN
        checks++;
        if (n_rep != 2) begin errors++; $display("FAIL rep_count got %0d want 2", n_rep); end
        checks++;
        if (rep_at[0] != 28) begin errors++; $display("FAIL rep_first_sample got %0d want 28", rep_at[0]); end
        checks++;
        if (rep_at[1] != 36) begin errors++; $display("FAIL rep_second_sample got %0d want 36", rep_at[1]); end
`else
        checks++;
        if (n_rep != 0) begin errors++; $display("FAIL rep_disabled got %0d want 0", n_rep); end
`endif
        checks++;
        if (n_short != 0) begin errors++; $display("FAIL rep_short got %0d want 0", n_short); end
    endtask

    task automatic test_held_through_reset();
        clear_counts();
        reset = 1'b1;
        cycles(1'b1, 2);
        reset = 1'b0;
        clear_counts();
        cycles(1'b1, 30);
        checks++;
        if ((n_short + n_long + n_rep) != 0) begin
            errors++; $display("FAIL hold_reset_strobes got %0d want 0", n_short + n_long + n_rep);
        end
        checks++;
        if (n_held != 0) begin errors++; $display("FAIL hold_reset_held got %0d want 0", n_held); end
        cycles(1'b0, 2);
        cycles(1'b1, 6);
        cycles(1'b0, 2);
        checks++;
        if (n_short != 1) begin errors++; $display("FAIL hold_reset_short got %0d want 1", n_short); end
    endtask

    task automatic test_reset_mid_press();
        clear_counts();
        cycles(1'b0, 2);
        cycles(1'b1, 9);
        reset = 1'b1;
        cyc(1'b1);
        checks++;
        if (held !== 1'b0) begin errors++; $display("FAIL midreset_held got %b want 1'b0", held); end
        reset = 1'b0;
        cycles(1'b1, 3);
        cycles(1'b0, 2);
        checks++;
        if ((n_short + n_long + n_rep) != 0) begin
            errors++; $display("FAIL midreset_strobes got %0d want 0", n_short + n_long + n_rep);
        end
        cycles(1'b1, 5);
        cycles(1'b0, 2);
        checks++;
        if (n_short != 1) begin errors++; $display("FAIL midreset_next_short got %0d want 1", n_short); end
        checks++;
        if (n_multi != 0) begin errors++; $display("FAIL midreset_one_hot got %0d want 0", n_multi); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        hi       = 0;
        reset    = 1'b1;
        boton_in = 1'b0;
        clear_counts();
        test_reset();
        test_short_press();
        test_glitch();
        test_boundary();
        test_auto_repeat();
        test_held_through_reset();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
